ps2_key_sequencer: RTL and testbench
====================================

Name: ps2_key_sequencer

Overview:
- Sits between the PS2_Controller byte stream and the game FSM.
- Power-up: runs a keyboard init sequence (reset command 0xFF, waits for ACK 0xFA and BAT 0xAA) with timeout and retry.
- Afterwards: parses Set-2 make/break/extended sequences into a held-key bitmap and one-cycle press pulses for the game's five control keys.
- Replaces ad-hoc "last byte" tracking with a proper prefix-aware parser.

Parameters:
- CLOCK_FREQUENCY, 25000000, Clock rate in Hz.
- TIMEOUT_MS, 1000, per-step init response timeout in ms; timeout cycles = CLOCK_FREQUENCY/1000*TIMEOUT_MS, counter width derived by $clog2.
- MAX_RETRIES, 3, init attempts before giving up.

Ports:
- Clock  input  1  system clock.
- reset  input  1  synchronous, active-low.
- rx_data  input  8  received byte from PS2_Controller.
- rx_valid  input  1  one-cycle strobe; rx_data valid.
- tx_cmd  output  8  command byte to PS2 transmitter.
- tx_send  output  1  one-cycle strobe to start transmit.
- tx_done  input  1  one-cycle strobe; transmit completed.
- tx_error  input  1  one-cycle strobe; transmit failed or timed out.
- keys_held  output  5  level, 1 while key down: [0] space(29), [1] up(E0 75), [2] down(E0 72), [3] enter(5A), [4] esc(76).
- keys_pressed  output  5  one-cycle pulse on make edge (0->1 of keys_held).
- init_done  output  1  high once RUN is entered; stays high until reset.
- init_fail  output  1  high if all retries are exhausted; sticky until reset.

Behaviour:
- Reset (reset=0 at posedge Clock): all outputs 0, tx_cmd=8'h00, retry count 0, parser in P_IDLE, init FSM in I_SEND.
- Reset asserted mid-operation aborts any step in the same cycle.
- Init FSM states: I_SEND, I_WAIT_TX, I_WAIT_ACK, I_WAIT_BAT, RUN.
  - I_SEND: tx_cmd=8'hFF, tx_send=1 for exactly one cycle, timer cleared -> I_WAIT_TX.
  - I_WAIT_TX: tx_done -> I_WAIT_ACK. tx_error or timeout -> retry.
  - I_WAIT_ACK: rx_valid with 8'hFA -> I_WAIT_BAT. Any other byte is ignored. Timeout -> retry.
  - I_WAIT_BAT: rx_valid with 8'hAA -> RUN. 8'hFC (BAT fail) or timeout -> retry.
  - Retry: increment count. If count < MAX_RETRIES -> I_SEND. Otherwise set init_fail=1 and go to RUN anyway, so a keyboard that never ACKs still works.
  - Entering RUN sets init_done=1 on the same edge.
  - Timer clears on every state change. Timeout fires when timer == limit-1.
- Parser runs only in RUN; bytes received before RUN never affect keys_held.
- Parser states: P_IDLE, P_EXT, P_BRK, P_EXT_BRK, P_SKIP.
  - P_IDLE: E0 -> P_EXT; F0 -> P_BRK; E1 -> P_SKIP with skip counter=7; any other byte is a make of a normal code -> P_IDLE.
  - P_EXT: F0 -> P_EXT_BRK; other byte is an extended make -> P_IDLE.
  - P_BRK: byte is a normal break -> P_IDLE.
  - P_EXT_BRK: byte is an extended break -> P_IDLE.
  - P_SKIP: ignore bytes until counter reaches 0 (Pause key) -> P_IDLE.
- Make sets the matching keys_held bit; break clears it. Unmapped codes change nothing.
- Extended and normal codes are distinct: 75 without E0 (keypad 8) does not map to bit 1.
- Typematic repeats (make while already held) keep the bit at 1 and produce no pulse.
- 8'hAA received in RUN (keyboard hot-plug) clears keys_held and returns the parser to P_IDLE.
- keys_held updates one cycle after the rx_valid edge. keys_pressed is a registered pulse, high the cycle after keys_held rises (latency 2 from rx_valid).
- rx_valid and tx_done arriving in the same cycle are both honoured; the FSM acts on the one relevant to its current state.

Decomposition:
- Shared package ps2_pkg holds:
  - scan-code constants: SC_EXT=E0, SC_BRK=F0, SC_PAUSE=E1, SC_ACK=FA, SC_BAT_OK=AA, SC_BAT_FAIL=FC, CMD_RESET=FF;
  - key codes 29/75/72/5A/76;
  - key index localparams KEY_JUMP..KEY_PAUSE;
  - both state enums.
- One sub-module: ps2_scan_parser (parser FSM + bitmap + edge pulses). The top holds the init FSM, timer and retry logic.

Test Plan:
- Normal init: after reset, expect tx_send with tx_cmd=FF; drive tx_done, rx FA, rx AA -> init_done=1, init_fail=0, keys_held=0.
- Retry/fail: MAX_RETRIES=3, short timeout, no response -> exactly 3 tx_send pulses, then init_fail=1 and init_done=1.
- Make/break: in RUN send 29, then F0 29 -> keys_held[0] rises one cycle after the first byte, keys_pressed[0] pulses once, bit clears after the F0 29 sequence completes.
- Extended: send E0 72, 72 (repeat), E0 F0 72 -> keys_held[2]=1 with a single pulse, then 0; a bare 75 leaves keys_held[1]=0.
- Pause skip: send E1 14 77 E1 F0 14 F0 77, then 5A -> no spurious bits, then keys_held[3]=1.
- Hot-plug/reset: hold bits 0 and 4, send AA -> keys_held=0. Assert reset mid-I_WAIT_ACK -> all outputs 0 next cycle and init restarts.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard front end: Set-2 scan codes,
// key bit positions and the state types of the init and parser FSMs.
package ps2_pkg;

    localparam logic [7:0] SC_EXT      = 8'hE0;
    localparam logic [7:0] SC_BRK      = 8'hF0;
    localparam logic [7:0] SC_PAUSE    = 8'hE1;
    localparam logic [7:0] SC_ACK      = 8'hFA;
    localparam logic [7:0] SC_BAT_OK   = 8'hAA;
    localparam logic [7:0] SC_BAT_FAIL = 8'hFC;
    localparam logic [7:0] CMD_RESET   = 8'hFF;

    localparam logic [7:0] KC_SPACE = 8'h29;
    localparam logic [7:0] KC_UP    = 8'h75;
    localparam logic [7:0] KC_DOWN  = 8'h72;
    localparam logic [7:0] KC_ENTER = 8'h5A;
    localparam logic [7:0] KC_ESC   = 8'h76;

    localparam int KEY_JUMP  = 0;
    localparam int KEY_UP    = 1;
    localparam int KEY_DOWN  = 2;
    localparam int KEY_ENTER = 3;
    localparam int KEY_PAUSE = 4;
    localparam int NUM_KEYS  = 5;

    // The Pause key sends E1 followed by seven more bytes that carry no key state.
    localparam logic [2:0] PAUSE_TAIL = 3'd7;

    typedef enum logic [2:0] {
        I_SEND,
        I_WAIT_TX,
        I_WAIT_ACK,
        I_WAIT_BAT,
        RUN
    } init_state_t;

    typedef enum logic [2:0] {
        P_IDLE,
        P_EXT,
        P_BRK,
        P_EXT_BRK,
        P_SKIP
    } parse_state_t;

    function automatic logic [NUM_KEYS-1:0] key_mask(input logic [7:0] code,
                                                     input logic       extended);
        logic [NUM_KEYS-1:0] mask;
        mask = '0;
        if (extended) begin
            if (code == KC_UP)
                mask[KEY_UP] = 1'b1;
            else if (code == KC_DOWN)
                mask[KEY_DOWN] = 1'b1;
        end else begin
            if (code == KC_SPACE)
                mask[KEY_JUMP] = 1'b1;
            else if (code == KC_ENTER)
                mask[KEY_ENTER] = 1'b1;
            else if (code == KC_ESC)
                mask[KEY_PAUSE] = 1'b1;
        end
        return mask;
    endfunction

endpackage

// File: rtl/ps2_scan_parser.sv
// Prefix-aware Set-2 parser: turns make/break/extended byte sequences into a
// held-key bitmap and single-cycle press pulses for the five game keys.
module ps2_scan_parser
    import ps2_pkg::*;
(
    input  logic                Clock,
    input  logic                reset,
    input  logic                enable,
    input  logic [7:0]          rx_data,
    input  logic                rx_valid,
    output logic [NUM_KEYS-1:0] keys_held,
    output logic [NUM_KEYS-1:0] keys_pressed
);

    parse_state_t        state;
    parse_state_t        state_next;
    logic [2:0]          skip_count;
    logic [2:0]          skip_next;
    logic [NUM_KEYS-1:0] held_next;
    logic [NUM_KEYS-1:0] held_prev;

    always_ff @(posedge Clock) begin
        if (!reset)
            state <= P_IDLE;
        else
            state <= state_next;
    end

    // A BAT-OK byte at any point means the keyboard was re-plugged, so all
    // partially parsed prefixes and held keys are discarded.
    always_comb begin
        state_next = state;
        skip_next  = skip_count;
        held_next  = keys_held;
        if (enable && rx_valid) begin
            if (rx_data == SC_BAT_OK) begin
                held_next  = '0;
                state_next = P_IDLE;
            end else begin
                case (state)
                    P_IDLE: begin
                        if (rx_data == SC_EXT) begin
                            state_next = P_EXT;
                        end else if (rx_data == SC_BRK) begin
                            state_next = P_BRK;
                        end else if (rx_data == SC_PAUSE) begin
                            state_next = P_SKIP;
                            skip_next  = PAUSE_TAIL;
                        end else begin
                            held_next = keys_held | key_mask(rx_data, 1'b0);
                        end
                    end
                    P_EXT: begin
                        if (rx_data == SC_BRK) begin
                            state_next = P_EXT_BRK;
                        end else begin
                            held_next  = keys_held | key_mask(rx_data, 1'b1);
                            state_next = P_IDLE;
                        end
                    end
                    P_BRK: begin
                        held_next  = keys_held & ~key_mask(rx_data, 1'b0);
                        state_next = P_IDLE;
                    end
                    P_EXT_BRK: begin
                        held_next  = keys_held & ~key_mask(rx_data, 1'b1);
                        state_next = P_IDLE;
                    end
                    P_SKIP: begin
                        skip_next = skip_count - 3'd1;
                        if (skip_count <= 3'd1)
                            state_next = P_IDLE;
                    end
                    default: state_next = P_IDLE;
                endcase
            end
        end
    end

    // Press pulses compare the bitmap against its previous value, so a
    // typematic repeat of an already-held key never pulses again.
    always_ff @(posedge Clock) begin
        if (!reset) begin
            skip_count   <= '0;
            keys_held    <= '0;
            held_prev    <= '0;
            keys_pressed <= '0;
        end else begin
            skip_count   <= skip_next;
            keys_held    <= held_next;
            held_prev    <= keys_held;
            keys_pressed <= keys_held & ~held_prev;
        end
    end

endmodule

// File: rtl/ps2_key_sequencer.sv
// Keyboard front end: resets the keyboard at power-up (with timeout and
// retry), then hands the byte stream to the scan-code parser.
module ps2_key_sequencer
    import ps2_pkg::*;
#(
    parameter int CLOCK_FREQUENCY = 25000000,
    parameter int TIMEOUT_MS      = 1000,
    parameter int MAX_RETRIES     = 3
) (
    input  logic                Clock,
    input  logic                reset,
    input  logic [7:0]          rx_data,
    input  logic                rx_valid,
    output logic [7:0]          tx_cmd,
    output logic                tx_send,
    input  logic                tx_done,
    input  logic                tx_error,
    output logic [NUM_KEYS-1:0] keys_held,
    output logic [NUM_KEYS-1:0] keys_pressed,
    output logic                init_done,
    output logic                init_fail
);

    localparam int TIMEOUT_CYCLES = CLOCK_FREQUENCY / 1000 * TIMEOUT_MS;
    localparam int TIMER_W        = $clog2(TIMEOUT_CYCLES + 1);
    localparam int RETRY_W        = $clog2(MAX_RETRIES + 1);

    init_state_t          state;
    init_state_t          state_next;
    logic [TIMER_W-1:0]   timer;
    logic [RETRY_W-1:0]   retry_count;
    logic [RETRY_W-1:0]   retry_next;
    logic                 timeout;
    logic                 waiting;
    logic                 retry;
    logic                 give_up;

    assign waiting = (state == I_WAIT_TX) || (state == I_WAIT_ACK) || (state == I_WAIT_BAT);
    assign timeout = waiting && (timer == TIMER_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge Clock) begin
        if (!reset)
            state <= I_SEND;
        else
            state <= state_next;
    end

    // An exhausted retry budget still lands in RUN so that a keyboard which
    // never answers the reset command remains usable.
    always_comb begin
        state_next = state;
        retry_next = retry_count;
        retry      = 1'b0;
        give_up    = 1'b0;
        case (state)
            I_SEND: state_next = I_WAIT_TX;
            I_WAIT_TX: begin
                if (tx_done)
                    state_next = I_WAIT_ACK;
                else if (tx_error || timeout)
                    retry = 1'b1;
            end
            I_WAIT_ACK: begin
                if (rx_valid && rx_data == SC_ACK)
                    state_next = I_WAIT_BAT;
                else if (timeout)
                    retry = 1'b1;
            end
            I_WAIT_BAT: begin
                if (rx_valid && rx_data == SC_BAT_OK)
                    state_next = RUN;
                else if ((rx_valid && rx_data == SC_BAT_FAIL) || timeout)
                    retry = 1'b1;
            end
            RUN:     state_next = RUN;
            default: state_next = I_SEND;
        endcase
        if (retry) begin
            retry_next = retry_count + RETRY_W'(1);
            if (retry_next < RETRY_W'(MAX_RETRIES)) begin
                state_next = I_SEND;
            end else begin
                give_up    = 1'b1;
                state_next = RUN;
            end
        end
    end

    // The step timer restarts on every state change and only runs while
    // waiting on the keyboard.
    always_ff @(posedge Clock) begin
        if (!reset) begin
            timer       <= '0;
            retry_count <= '0;
            tx_send     <= 1'b0;
            tx_cmd      <= 8'h00;
            init_done   <= 1'b0;
            init_fail   <= 1'b0;
        end else begin
            retry_count <= retry_next;
            timer       <= (state_next != state || !waiting) ? '0 : timer + TIMER_W'(1);
            tx_send     <= (state == I_SEND);
            if (state == I_SEND)
                tx_cmd <= CMD_RESET;
            if (state_next == RUN)
                init_done <= 1'b1;
            if (give_up)
                init_fail <= 1'b1;
        end
    end

    ps2_scan_parser u_parser (
        .Clock        (Clock),
        .reset        (reset),
        .enable       (state == RUN),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .keys_held    (keys_held),
        .keys_pressed (keys_pressed)
    );

endmodule

// File: tb/tb_ps2_key_sequencer.sv
// Randomized self-checking bench for ps2_key_sequencer: init handshake, retries,
// and key sequences compared against a sequence-level key model.
module tb_ps2_key_sequencer;

    localparam int CLK_HZ  = 20000;
    localparam int TO_MS   = 1;
    localparam int RETRIES = 3;
    localparam int TO_CYC  = CLK_HZ / 1000 * TO_MS;

    localparam int K_MAKE      = 0;
    localparam int K_BREAK     = 1;
    localparam int K_MAKE_EXT  = 2;
    localparam int K_BREAK_EXT = 3;
    localparam int K_PAUSE     = 4;
    localparam int K_HOTPLUG   = 5;

    logic       Clock = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic [7:0] tx_cmd;
    logic       tx_send;
    logic       tx_done = 1'b0;
    logic       tx_error = 1'b0;
    logic [4:0] keys_held;
    logic [4:0] keys_pressed;
    logic       init_done;
    logic       init_fail;

    int total = 0;
    int bad   = 0;

    logic [4:0] model_held;
    logic [7:0] seq_q[$];
    logic [7:0] map_code [5] = '{8'h29, 8'h75, 8'h72, 8'h5A, 8'h76};
    bit         map_ext  [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    ps2_key_sequencer #(
        .CLOCK_FREQUENCY (CLK_HZ),
        .TIMEOUT_MS      (TO_MS),
        .MAX_RETRIES     (RETRIES)
    ) dut (
        .Clock        (Clock),
        .reset        (reset),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .tx_cmd       (tx_cmd),
        .tx_send      (tx_send),
        .tx_done      (tx_done),
        .tx_error     (tx_error),
        .keys_held    (keys_held),
        .keys_pressed (keys_pressed),
        .init_done    (init_done),
        .init_fail    (init_fail)
    );

    always #5 Clock = ~Clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    function automatic logic [4:0] modelBit(input logic [7:0] code, input bit ext);
        logic [4:0] r;
        r = '0;
        for (int i = 0; i < 5; i++)
            if (map_code[i] == code && map_ext[i] == ext)
                r[i] = 1'b1;
        return r;
    endfunction

    function automatic logic [7:0] randCode();
        logic [7:0] c;
        do
            c = 8'($urandom_range(0, 255));
        while (c == 8'hE0 || c == 8'hF0 || c == 8'hE1 || c == 8'hAA);
        return c;
    endfunction

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_tx_cmd"}, tx_cmd, 8'h00);
        checkOutput({tag, "_tx_send"}, tx_send, 1'b0);
        checkOutput({tag, "_held"}, keys_held, 5'h00);
        checkOutput({tag, "_pressed"}, keys_pressed, 5'h00);
        checkOutput({tag, "_done"}, init_done, 1'b0);
        checkOutput({tag, "_fail"}, init_fail, 1'b0);
    endtask

    task automatic doReset(input string tag);
        reset = 1'b0;
        tick();
        tick();
        checkIdle(tag);
        reset = 1'b1;
        model_held = '0;
    endtask

    task automatic waitSend(input string tag);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 100 && !seen; n++) begin
            tick();
            if (tx_send)
                seen = 1'b1;
        end
        checkOutput({tag, "_seen"}, seen, 1'b1);
        checkOutput({tag, "_cmd"}, tx_cmd, 8'hFF);
        tick();
        checkOutput({tag, "_one_cycle"}, tx_send, 1'b0);
    endtask

    task automatic pulseDone();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
    endtask

    task automatic pulseError();
        tx_error = 1'b1;
        tick();
        tx_error = 1'b0;
    endtask

    task automatic rxByte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    // One whole key sequence; the model changes only when the sequence ends.
    task automatic applyStimulus(input int kind, input logic [7:0] code);
        logic [4:0] old_held;
        logic [4:0] new_held;
        bit         last;
        seq_q.delete();
        old_held = model_held;
        new_held = model_held;
        case (kind)
            K_MAKE: begin
                seq_q.push_back(code);
                new_held = old_held | modelBit(code, 1'b0);
            end
            K_BREAK: begin
                seq_q.push_back(8'hF0);
                seq_q.push_back(code);
                new_held = old_held & ~modelBit(code, 1'b0);
            end
            K_MAKE_EXT: begin
                seq_q.push_back(8'hE0);
                seq_q.push_back(code);
                new_held = old_held | modelBit(code, 1'b1);
            end
            K_BREAK_EXT: begin
                seq_q.push_back(8'hE0);
                seq_q.push_back(8'hF0);
                seq_q.push_back(code);
                new_held = old_held & ~modelBit(code, 1'b1);
            end
            K_PAUSE: begin
                seq_q.push_back(8'hE1);
                seq_q.push_back(8'h14);
                seq_q.push_back(8'h77);
                seq_q.push_back(8'hE1);
                seq_q.push_back(8'hF0);
                seq_q.push_back(8'h14);
                seq_q.push_back(8'hF0);
                seq_q.push_back(8'h77);
            end
            default: begin
                seq_q.push_back(8'hAA);
                new_held = '0;
            end
        endcase
        foreach (seq_q[i]) begin
            last = (i == seq_q.size() - 1);
            rxByte(seq_q[i]);
            checkOutput($sformatf("held_k%0d_b%0h", kind, seq_q[i]), keys_held, last ? new_held : old_held);
            checkOutput("pressed_early", keys_pressed, 5'h00);
            tick();
            checkOutput($sformatf("pressed_k%0d_b%0h", kind, seq_q[i]), keys_pressed,
                        last ? (new_held & ~old_held) : 5'h00);
        end
        model_held = new_held;
    endtask

    initial begin
        int sends;
        int first_send;
        int second_send;
        int kind;
        logic [7:0] code;

        model_held = '0;
        doReset("reset");

        // Normal init, with stray bytes that must not advance or affect keys.
        waitSend("init_send");
        rxByte(8'hFA);
        pulseDone();
        rxByte(8'h29);
        rxByte(8'hAA);
        checkOutput("ack_wait_done", init_done, 1'b0);
        rxByte(8'hFA);
        checkOutput("bat_wait_done", init_done, 1'b0);
        rxByte(8'hAA);
        checkOutput("init_done", init_done, 1'b1);
        checkOutput("init_fail", init_fail, 1'b0);
        checkOutput("init_held", keys_held, 5'h00);
        tick();

        // Directed key sequences.
        applyStimulus(K_MAKE, 8'h29);
        applyStimulus(K_BREAK, 8'h29);
        applyStimulus(K_MAKE_EXT, 8'h72);
        applyStimulus(K_MAKE_EXT, 8'h72);
        applyStimulus(K_MAKE, 8'h72);
        applyStimulus(K_BREAK_EXT, 8'h72);
        applyStimulus(K_MAKE, 8'h75);
        applyStimulus(K_PAUSE, 8'h00);
        applyStimulus(K_MAKE, 8'h5A);
        applyStimulus(K_MAKE, 8'h29);
        applyStimulus(K_MAKE, 8'h76);
        applyStimulus(K_HOTPLUG, 8'h00);
        checkOutput("hotplug_model", model_held, 5'h00);

        // Random sequences.
        for (int s = 0; s < 80; s++) begin
            kind = int'($urandom_range(0, 9));
            code = ($urandom_range(0, 1) == 1) ? map_code[$urandom_range(0, 4)] : randCode();
            if (kind <= 2)
                applyStimulus(K_MAKE, code);
            else if (kind <= 4)
                applyStimulus(K_BREAK, code);
            else if (kind <= 6)
                applyStimulus(K_MAKE_EXT, code);
            else if (kind <= 8)
                applyStimulus(K_BREAK_EXT, code);
            else
                applyStimulus(($urandom_range(0, 3) == 0) ? K_HOTPLUG : K_PAUSE, code);
        end

        // Reset in the middle of RUN and again while waiting for ACK.
        applyStimulus(K_MAKE, 8'h29);
        doReset("run_reset");
        waitSend("rr_send");
        pulseDone();
        reset = 1'b0;
        tick();
        checkIdle("mid_ack");
        reset = 1'b1;
        waitSend("restart_send");
        pulseDone();
        rxByte(8'hFA);
        rxByte(8'hAA);
        checkOutput("restart_done", init_done, 1'b1);
        checkOutput("restart_held", keys_held, 5'h00);

        // Two failed attempts (tx_error, then BAT fail) followed by success.
        doReset("retry_reset");
        waitSend("retry_send1");
        pulseError();
        waitSend("retry_send2");
        checkOutput("retry_not_done", init_done, 1'b0);
        pulseDone();
        rxByte(8'hFA);
        rxByte(8'hFC);
        waitSend("retry_send3");
        pulseDone();
        rxByte(8'hFA);
        rxByte(8'hAA);
        checkOutput("retry_done", init_done, 1'b1);
        checkOutput("retry_fail", init_fail, 1'b0);

        // No response at all: every attempt times out.
        doReset("fail_reset");
        sends = 0;
        first_send = -1;
        second_send = -1;
        for (int c = 0; c < 400 && !init_done; c++) begin
            tick();
            if (tx_send) begin
                sends++;
                if (sends == 1)
                    first_send = c;
                else if (sends == 2)
                    second_send = c;
            end
        end
        checkOutput("fail_sends", sends, RETRIES);
        checkOutput("fail_gap", second_send - first_send, TO_CYC + 1);
        checkOutput("fail_done", init_done, 1'b1);
        checkOutput("fail_flag", init_fail, 1'b1);
        tick();
        applyStimulus(K_MAKE, 8'h5A);
        applyStimulus(K_MAKE_EXT, 8'h75);
        checkOutput("fail_sticky", init_fail, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
